// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: sequential instruction fetch with up to DEPTH outstanding requests
// feeding an in-order decode queue; redirects flush the queue and drop stale responses.
module fetch_queue_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [AW-1:0] PTR1 = AW'(1);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic            accept, rsp, push, pop, empty;
    logic [XLEN-1:0] target;

    assign target    = redirect_pc & ~XLEN'(3);
    assign empty     = count_q == '0;
    // queued plus outstanding never exceeds DEPTH, so a push can never find the queue full
    assign imem_req  = !reset && !redirect && ({1'b0, count_q} + {1'b0, inflight_q} < LIMIT);
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_gnt;
    assign rsp       = imem_rvalid && inflight_q != '0;
    assign push      = rsp && drop_q == '0 && !redirect;
    assign out_valid = !empty && !redirect;
    assign pop       = out_valid && out_ready;
    assign out_inst  = empty ? NOP_INSTR : inst_mem[rd_ptr_q];
    assign out_pc    = empty ? '0 : pc_mem[rd_ptr_q];
    assign out_pc4   = empty ? '0 : pc_mem[rd_ptr_q] + FOUR;

    always_comb begin
        inflight_d = inflight_q + (accept ? ONE : '0) - (rsp ? ONE : '0);
        fetch_pc_d = redirect ? target : accept ? fetch_pc_q + FOUR : fetch_pc_q;
        resp_pc_d  = redirect ? target : push ? resp_pc_q + FOUR : resp_pc_q;
        drop_d     = redirect ? inflight_d : (rsp && drop_q != '0) ? drop_q - ONE : drop_q;
        count_d    = redirect ? '0 : count_q + (push ? ONE : '0) - (pop ? ONE : '0);
        rd_ptr_d   = redirect ? '0 : pop ? rd_ptr_q + PTR1 : rd_ptr_q;
        wr_ptr_d   = redirect ? '0 : push ? wr_ptr_q + PTR1 : wr_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: random and directed traffic against a request-list reference model
// of the fetch queue, with an in-order variable-latency instruction memory.
module tb_fetch_queue_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP = 32'h0;
    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic clk, reset, redirect, imem_req, imem_gnt, imem_rvalid, out_valid, out_ready;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, out_inst, out_pc, out_pc4;

    fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_pc4(out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit live; } req_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;
    req_t mo[$];
    logic [31:0] mq[$];
    mem_t mem[$];
    logic [31:0] m_fpc;

    int checks, errors, cyc, lat;
    bit redir_v, gnt_v, rdy_v, spur_v;
    logic [31:0] redir_pc_v;
    logic s_req, s_valid, s_rv;
    logic [31:0] s_addr, s_inst, s_pc, s_pc4;

    task automatic clear_model();
        mem.delete();
        mo.delete();
        mq.delete();
        m_fpc = RESET_PC;
    endtask

    task automatic step();
        bit rv_real, rv, e_req, e_valid;
        logic [31:0] e_inst, e_pc, e_pc4;
        req_t r;
        rv_real = mem.size() > 0 && mem[0].due <= cyc;
        rv = rv_real || (spur_v && mem.size() == 0);
        redirect = redir_v;
        redirect_pc = redir_pc_v;
        imem_gnt = gnt_v;
        out_ready = rdy_v;
        imem_rvalid = rv;
        imem_rdata = rv_real ? (mem[0].addr ^ K) : $urandom;
        @(negedge clk);
        e_req = !redir_v && (mq.size() + mo.size() < DEPTH);
        e_valid = mq.size() > 0 && !redir_v;
        e_pc = mq.size() > 0 ? mq[0] : 32'h0;
        e_inst = mq.size() > 0 ? (mq[0] ^ K) : NOP;
        e_pc4 = mq.size() > 0 ? mq[0] + 32'd4 : 32'h0;
        checks += 6;
        if (imem_req !== e_req) begin errors++; $display("FAIL req cyc=%0d got %b want %b", cyc, imem_req, e_req); end
        if (imem_addr !== m_fpc) begin errors++; $display("FAIL addr cyc=%0d got %h want %h", cyc, imem_addr, m_fpc); end
        if (out_valid !== e_valid) begin errors++; $display("FAIL valid cyc=%0d got %b want %b", cyc, out_valid, e_valid); end
        if (out_pc !== e_pc) begin errors++; $display("FAIL out_pc cyc=%0d got %h want %h", cyc, out_pc, e_pc); end
        if (out_pc4 !== e_pc4) begin errors++; $display("FAIL out_pc4 cyc=%0d got %h want %h", cyc, out_pc4, e_pc4); end
        if (out_inst !== e_inst) begin errors++; $display("FAIL out_inst cyc=%0d got %h want %h", cyc, out_inst, e_inst); end
        s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_inst = out_inst;
        s_pc = out_pc; s_pc4 = out_pc4; s_rv = rv;
        if (rv_real) void'(mem.pop_front());
        if (imem_req === 1'b1 && imem_gnt) mem.push_back('{imem_addr, cyc + lat});
        if (e_valid && rdy_v) void'(mq.pop_front());
        if (rv && mo.size() > 0) begin
            r = mo.pop_front();
            if (r.live && !redir_v) mq.push_back(r.pc);
        end
        if (e_req && gnt_v) begin
            mo.push_back('{m_fpc, 1'b1});
            m_fpc = m_fpc + 32'd4;
        end
        if (redir_v) begin
            mq.delete();
            foreach (mo[i]) mo[i].live = 1'b0;
            m_fpc = {redir_pc_v[31:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        redir_v = 0; spur_v = 0; gnt_v = 1; rdy_v = 1; lat = 1; redir_pc_v = 32'h0;
        redirect = 0; imem_rvalid = 0; imem_gnt = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        clear_model();
        repeat (2) begin @(posedge clk); cyc++; end
        #1 reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        if (out_inst !== NOP) begin errors++; $display("FAIL rst_inst got %h want %h", out_inst, NOP); end
        if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr got %h want %h", imem_addr, RESET_PC); end
        if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        @(posedge clk); cyc++;
        #1 reset = 0;
        step();
        checks++;
        if (s_req !== 1'b1) begin errors++; $display("FAIL rst_release_req got %b want 1", s_req); end
    endtask

    task automatic test_stream();
        logic [31:0] ep;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step();
            if (k >= 2) begin
                ep = 32'(4 * (k - 2));
                checks += 3;
                if (s_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got %b want 1", k, s_valid); end
                if (s_pc !== ep) begin errors++; $display("FAIL stream_pc k=%0d got %h want %h", k, s_pc, ep); end
                if (s_inst !== (ep ^ K)) begin errors++; $display("FAIL stream_inst k=%0d got %h want %h", k, s_inst, ep ^ K); end
            end
        end
    endtask

    task automatic test_backpressure();
        int nrv;
        do_reset();
        rdy_v = 0;
        nrv = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_rv) nrv++;
        end
        checks += 3;
        if (nrv !== 4) begin errors++; $display("FAIL bp_responses got %0d want 4", nrv); end
        if (s_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got %b want 0", s_req); end
        if (s_pc !== 32'h0) begin errors++; $display("FAIL bp_head got %h want 0", s_pc); end
        rdy_v = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks += 2;
            if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid k=%0d got %b want 1", k, s_valid); end
            if (s_pc !== 32'(4 * k)) begin errors++; $display("FAIL bp_drain_pc k=%0d got %h want %h", k, s_pc, 32'(4 * k)); end
        end
    endtask

    task automatic test_redirect_drop();
        int n;
        do_reset();
        lat = 3;
        repeat (2) step();
        redir_v = 1; redir_pc_v = 32'h103;
        step();
        redir_v = 0;
        n = 0;
        do begin step(); n++; end while (!s_valid && n < 12);
        checks += 4;
        if (n !== 5) begin errors++; $display("FAIL drop_latency got %0d want 5", n); end
        if (s_pc !== 32'h100) begin errors++; $display("FAIL drop_pc got %h want 00000100", s_pc); end
        if (s_pc4 !== 32'h104) begin errors++; $display("FAIL drop_pc4 got %h want 00000104", s_pc4); end
        if (s_inst !== (32'h100 ^ K)) begin errors++; $display("FAIL drop_inst got %h want %h", s_inst, 32'h100 ^ K); end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        repeat (6) step();
        redir_v = 1; redir_pc_v = 32'h2000;
        step();
        checks += 2;
        if (s_rv !== 1'b1) begin errors++; $display("FAIL same_rvalid_present got %b want 1", s_rv); end
        if (s_valid !== 1'b0) begin errors++; $display("FAIL same_valid got %b want 0", s_valid); end
        redir_v = 0;
        step();
        checks += 4;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL same_empty got %b want 0", s_valid); end
        if (s_inst !== NOP) begin errors++; $display("FAIL same_nop got %h want %h", s_inst, NOP); end
        if (s_req !== 1'b1) begin errors++; $display("FAIL same_req got %b want 1", s_req); end
        if (s_addr !== 32'h2000) begin errors++; $display("FAIL same_addr got %h want 00002000", s_addr); end
        repeat (2) step();
        checks += 2;
        if (s_valid !== 1'b1) begin errors++; $display("FAIL same_lat_valid got %b want 1", s_valid); end
        if (s_pc !== 32'h2000) begin errors++; $display("FAIL same_lat_pc got %h want 00002000", s_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        redir_v = 1; redir_pc_v = 32'hFFFF_FFFC;
        step();
        redir_v = 0;
        repeat (3) step();
        checks += 3;
        if (s_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffc", s_pc); end
        if (s_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", s_pc4); end
        if (s_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", s_valid); end
        step();
        checks++;
        if (s_pc !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", s_pc); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        lat = 2;
        repeat (4) step();
        redir_v = 1; redir_pc_v = 32'h300;
        step();
        redir_pc_v = 32'h502;
        step();
        redir_v = 0;
        n = 0;
        do begin step(); n++; end while (!s_valid && n < 10);
        checks += 2;
        if (s_valid !== 1'b1) begin errors++; $display("FAIL b2b_timeout got %b want 1", s_valid); end
        if (s_pc !== 32'h500) begin errors++; $display("FAIL b2b_pc got %h want 00000500", s_pc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            gnt_v = $urandom_range(0, 3) != 0;
            rdy_v = $urandom_range(0, 9) < 7;
            lat = $urandom_range(1, 4);
            redir_v = $urandom_range(0, 15) == 0;
            redir_pc_v = $urandom;
            spur_v = $urandom_range(0, 19) == 0;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_midstream_reset();
        do_reset();
        rdy_v = 0;
        repeat (12) step();
        #2 reset = 1;
        redirect = 0; imem_rvalid = 0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        if (out_inst !== NOP) begin errors++; $display("FAIL mid_rst_inst got %h want %h", out_inst, NOP); end
        if (imem_addr !== RESET_PC) begin errors++; $display("FAIL mid_rst_addr got %h want %h", imem_addr, RESET_PC); end
        if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", imem_req); end
        idle_inputs();
        clear_model();
        @(posedge clk); cyc++;
        #1 reset = 0;
        step();
        checks += 2;
        if (s_req !== 1'b1) begin errors++; $display("FAIL mid_release_req got %b want 1", s_req); end
        if (s_addr !== RESET_PC) begin errors++; $display("FAIL mid_release_addr got %h want %h", s_addr, RESET_PC); end
        repeat (8) step();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        reset = 1;
        idle_inputs();
        redirect_pc = 32'h0; imem_rdata = 32'h0;
        clear_model();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_wrap();
        test_back_to_back();
        test_random();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
